sm_trace_buf: RTL and testbench

- Synthesizable on-chip instruction trace recorder for the schoolMIPS core.
- Replaces the simulation-only $write trace and cycle-timeout of the bench with hardware that works on FPGA.
- Captures retired (pc, instr, cycle stamp) records into a parametrised ring buffer, with PC trigger, post-trigger count and watchdog timeout.
- Contents are read out oldest-first through a simple request/valid port.

---
 rtl/sm_trace_buf.sv | 169 ++++++++++++++++
 tb/tb_sm_trace_buf.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_trace_buf.sv
// Instruction trace recorder: ring buffer of retired (pc, instr, cycle) records with PC trigger,
// post-trigger count and watchdog stop; oldest-first readout. Optional macro: SM_TRACE_CYCLE_STAMP_EN.
module sm_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT   = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [31:0]   trig_pc,
  input  logic          trace_valid,
  input  logic [31:0]   trace_pc,
  input  logic [31:0]   trace_instr,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [31:0]   rd_cycle,
  output logic          rd_empty,
  output logic [AW:0]   count,
  output logic [1:0]    state,
  output logic          triggered,
  output logic          timeout
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LD = AW'(POST_TRIG);
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   rd_idx_q, rd_idx_d;
  logic [AW-1:0] post_q, post_d;
  logic          trig_q, trig_d;
  logic          to_q, to_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_pc_q, rd_instr_q, rd_cycle_q;

  logic          running, cap, rd_fire;
  logic [AW-1:0] rd_addr;

  logic [31:0] mem_pc    [DEPTH];
  logic [31:0] mem_instr [DEPTH];

  assign running = (state_q == S_RUN) || (state_q == S_POST);
  assign cap     = running && trace_valid && !arm;
  assign rd_fire = !arm && (state_q == S_DONE) && rd_req && (rd_idx_q < count_q);
  // Once the ring has wrapped, the oldest entry sits at the write pointer.
  assign rd_addr = ((count_q == FULL) ? wr_ptr_q : '0) + rd_idx_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    post_d     = post_q;
    trig_d     = trig_q;
    to_d       = to_q;
    rd_valid_d = 1'b0;
    if (arm) begin
      state_d  = S_RUN;
      cyc_d    = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      rd_idx_d = '0;
      post_d   = '0;
      trig_d   = 1'b0;
      to_d     = 1'b0;
    end else begin
      if (running) cyc_d = cyc_q + 32'd1;
      if (cap) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (count_q != FULL) count_d = count_q + 1'b1;
      end
      case (state_q)
        S_RUN: if (cap && trig_en && (trace_pc == trig_pc)) begin
          trig_d  = 1'b1;
          post_d  = POST_LD;
          state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
        end
        S_POST: if (cap) begin
          post_d = post_q - 1'b1;
          if (post_q == 1) state_d = S_DONE;
        end
        S_DONE: if (rd_fire) begin
          rd_idx_d   = rd_idx_q + 1'b1;
          rd_valid_d = 1'b1;
        end
        default: ;
      endcase
      // The watchdog overrides any trigger seen in the same cycle.
      if (running && (cyc_q == TO_LAST)) begin
        state_d = S_DONE;
        to_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_idx_q   <= '0;
      post_q     <= '0;
      trig_q     <= 1'b0;
      to_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rd_idx_q   <= rd_idx_d;
      post_q     <= post_d;
      trig_q     <= trig_d;
      to_q       <= to_d;
      rd_valid_q <= rd_valid_d;
      if (rd_fire) begin
        rd_pc_q    <= mem_pc[rd_addr];
        rd_instr_q <= mem_instr[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem_pc[wr_ptr_q]    <= trace_pc;
      mem_instr[wr_ptr_q] <= trace_instr;
    end
  end

`ifdef SM_TRACE_CYCLE_STAMP_EN
  logic [31:0] mem_cyc [DEPTH];

  always_ff @(posedge clk) begin
    if (cap) mem_cyc[wr_ptr_q] <= cyc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_cycle_q <= '0;
    else if (rd_fire) rd_cycle_q <= mem_cyc[rd_addr];
  end
`else
  assign rd_cycle_q = '0;
`endif

  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_pc_q;
  assign rd_instr  = rd_instr_q;
  assign rd_cycle  = rd_cycle_q;
  assign rd_empty  = (state_q == S_IDLE) ? 1'b1 : (rd_idx_q == count_q);
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = trig_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_sm_trace_buf.sv
// Directed bench for sm_trace_buf: main instance (POST_TRIG=8) plus a POST_TRIG=0 instance on shared inputs.
module tb_sm_trace_buf;
  logic clk = 1'b0, rst = 1'b1, arm = 1'b0, trig_en = 1'b0, trace_valid = 1'b0, rd_req = 1'b0;
  logic [31:0] trig_pc = '0, trace_pc = '0, trace_instr = '0;

  logic        rd_valid, rd_empty, triggered, timeout;
  logic [31:0] rd_pc, rd_instr, rd_cycle;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        rd_valid0, rd_empty0, triggered0, timeout0;
  logic [31:0] rd_pc0, rd_instr0, rd_cycle0;
  logic [4:0]  count0;
  logic [1:0]  state0;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_cyc;

  always #5 clk = ~clk;

  sm_trace_buf #(.DEPTH(16), .AW(4), .POST_TRIG(8), .TIMEOUT(120)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_cycle(rd_cycle), .rd_empty(rd_empty), .count(count), .state(state),
    .triggered(triggered), .timeout(timeout));

  sm_trace_buf #(.DEPTH(16), .AW(4), .POST_TRIG(0), .TIMEOUT(120)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .rd_req(rd_req), .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_instr(rd_instr0),
    .rd_cycle(rd_cycle0), .rd_empty(rd_empty0), .count(count0), .state(state0),
    .triggered(triggered0), .timeout(timeout0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      if (state == 2'd3) break;
      tick();
    end
    n_cmp++;
    if (state !== 2'd3) begin n_err++; $display("FAIL wait_done state=%0d want 3", state); end
  endtask

  // Feeds pcs 0,4,8,... until the main instance stops; trigger at 0x28.
  task automatic trig_capture();
    trig_en = 1'b1;
    trig_pc = 32'h28;
    do_arm();
    for (int i = 0; i < 25; i++) begin
      trace_valid = 1'b1;
      trace_pc    = 32'(4 * i);
      trace_instr = 32'hA000_0000 | 32'(i);
      tick();
    end
    trace_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0 || rd_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_state state=%0d count=%0d empty=%0b want 0/0/1", state, count, rd_empty);
    end
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_pc !== 32'd0 || rd_cycle !== 32'd0 || triggered !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_outs valid=%0b pc=%0h cyc=%0h trig=%0b to=%0b want zeros", rd_valid, rd_pc, rd_cycle, triggered, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    // Mid-run asynchronous reset.
    do_arm();
    trace_valid = 1'b1;
    trace_pc = 32'h10;
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (state !== 2'd1 || count !== 5'd2 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL run_capture state=%0d count=%0d rd_valid=%0b want 1/2/0", state, count, rd_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (state !== 2'd0 || count !== 5'd0 || rd_empty !== 1'b1) begin
      n_err++; $display("FAIL async_reset state=%0d count=%0d empty=%0b want 0/0/1", state, count, rd_empty);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    trace_valid = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || state !== 2'd0) begin
      n_err++; $display("FAIL idle_ignore count=%0d state=%0d want 0/0", count, state);
    end
  endtask

  task automatic test_wrap();
    trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) begin
      trace_valid = 1'b1;
      trace_pc    = 32'(4 * i);
      trace_instr = 32'hB000_0000 | 32'(i);
      tick();
    end
    trace_valid = 1'b0;
    wait_done();
    n_cmp++;
    if (timeout !== 1'b1 || count !== 5'd16 || triggered !== 1'b0) begin
      n_err++; $display("FAIL wrap_flags to=%0b count=%0d trig=%0b want 1/16/0", timeout, count, triggered);
    end
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
`ifdef SM_TRACE_CYCLE_STAMP_EN
      exp_cyc = 32'(4 + i);
`else
      exp_cyc = 32'd0;
`endif
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'(16 + 4 * i) || rd_instr !== (32'hB000_0000 | 32'(4 + i)) || rd_cycle !== exp_cyc) begin
        n_err++; $display("FAIL wrap_read%0d valid=%0b pc=%0h instr=%0h cyc=%0d want 1/%0h/%0h/%0d", i, rd_valid, rd_pc, rd_instr, rd_cycle, 16 + 4 * i, 32'hB000_0000 | 32'(4 + i), exp_cyc);
      end
    end
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin
      n_err++; $display("FAIL wrap_extra valid=%0b empty=%0b want 0/1", rd_valid, rd_empty);
    end
  endtask

  task automatic test_trigger();
    trig_capture();
    n_cmp++;
    if (state !== 2'd3 || triggered !== 1'b1 || timeout !== 1'b0 || count !== 5'd16) begin
      n_err++; $display("FAIL trig_flags state=%0d trig=%0b to=%0b count=%0d want 3/1/0/16", state, triggered, timeout, count);
    end
    rd_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'(12 + 4 * i)) begin
        n_err++; $display("FAIL trig_read%0d valid=%0b pc=%0h want 1/%0h", i, rd_valid, rd_pc, 12 + 4 * i);
      end
    end
    rd_req = 1'b0;
    n_cmp++;
    if (rd_pc !== 32'h48 || rd_empty !== 1'b1) begin
      n_err++; $display("FAIL trig_last pc=%0h empty=%0b want 48/1", rd_pc, rd_empty);
    end
  endtask

  task automatic test_post_zero();
    trig_en = 1'b1;
    trig_pc = 32'h0;
    do_arm();
    tick();
    trace_valid = 1'b1;
    trace_pc = 32'h0;
    trace_instr = 32'hC0DE_0001;
    tick();
    trace_valid = 1'b0;
    n_cmp++;
    if (state0 !== 2'd3 || count0 !== 5'd1 || triggered0 !== 1'b1 || timeout0 !== 1'b0) begin
      n_err++; $display("FAIL post0_flags state=%0d count=%0d trig=%0b to=%0b want 3/1/1/0", state0, count0, triggered0, timeout0);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
`ifdef SM_TRACE_CYCLE_STAMP_EN
    exp_cyc = 32'd1;
`else
    exp_cyc = 32'd0;
`endif
    n_cmp++;
    if (rd_valid0 !== 1'b1 || rd_pc0 !== 32'h0 || rd_instr0 !== 32'hC0DE_0001 || rd_cycle0 !== exp_cyc || rd_empty0 !== 1'b1) begin
      n_err++; $display("FAIL post0_read valid=%0b pc=%0h instr=%0h cyc=%0d empty=%0b want 1/0/c0de0001/%0d/1", rd_valid0, rd_pc0, rd_instr0, rd_cycle0, rd_empty0, exp_cyc);
    end
    n_cmp++;
    if (rd_valid !== 1'b0 || state !== 2'd2) begin
      n_err++; $display("FAIL post_ignore_rd valid=%0b state=%0d want 0/2", rd_valid, state);
    end
  endtask

  task automatic test_trig_timeout();
    trig_en = 1'b1;
    trig_pc = 32'h500;
    do_arm();
    repeat (119) tick();
    trace_valid = 1'b1;
    trace_pc = 32'h500;
    tick();
    trace_valid = 1'b0;
    n_cmp++;
    if (state !== 2'd3 || triggered !== 1'b1 || timeout !== 1'b1 || count !== 5'd1) begin
      n_err++; $display("FAIL trig_timeout state=%0d trig=%0b to=%0b count=%0d want 3/1/1/1", state, triggered, timeout, count);
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_pc !== 32'h500) begin
      n_err++; $display("FAIL trig_timeout_read valid=%0b pc=%0h want 1/500", rd_valid, rd_pc);
    end
  endtask

  task automatic test_rearm();
    trig_capture();
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'(12 + 4 * i)) begin
        n_err++; $display("FAIL rearm_pre%0d valid=%0b pc=%0h want 1/%0h", i, rd_valid, rd_pc, 12 + 4 * i);
      end
    end
    rd_req = 1'b0;
    trig_en = 1'b0;
    do_arm();
    n_cmp++;
    if (state !== 2'd1 || count !== 5'd0 || rd_empty !== 1'b1 || triggered !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL rearm_clear state=%0d count=%0d empty=%0b trig=%0b to=%0b want 1/0/1/0/0", state, count, rd_empty, triggered, timeout);
    end
    for (int i = 0; i < 2; i++) begin
      trace_valid = 1'b1;
      trace_pc = 32'h100 + 32'(4 * i);
      tick();
    end
    trace_valid = 1'b0;
    wait_done();
    n_cmp++;
    if (count !== 5'd2 || timeout !== 1'b1) begin
      n_err++; $display("FAIL rearm_done count=%0d to=%0b want 2/1", count, timeout);
    end
    rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_pc !== 32'h100 + 32'(4 * i)) begin
        n_err++; $display("FAIL rearm_read%0d valid=%0b pc=%0h want 1/%0h", i, rd_valid, rd_pc, 32'h100 + 32'(4 * i));
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_trigger();
    test_post_zero();
    test_trig_timeout();
    test_rearm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
